data_path_gen: RTL and testbench

- Parametrised successor of the 8-bit accumulator datapath.
- A/B accumulators become an NREGS-entry register file with independent ALU-A, ALU-B and write selects.
- Internal ALU with NZVC flags, PC/MAR/IR/CCR.
- New: a memory-ready handshake that stalls memory-sourced loads until read data is valid. Sits between control_unit and memory; control_unit must honour busy.

---
 rtl/data_path_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_data_path_gen.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_path_gen.sv
// data_path_gen: parametrised processor datapath.
// Contains a register file, an ALU with NZVC flags, PC/MAR/IR/CCR, combinational
// TO/FROM memory buses, and a two-state handshake FSM. The FSM holds back loads
// from memory until the memory read data is valid.
module data_path_gen #(
    parameter int WIDTH     = 8,
    parameter int NREGS     = 4,
    parameter int REG_SEL_W = 2     // must equal $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,                // synchronous, active low
    input  logic [WIDTH-1:0]     from_memory,
    input  logic                 mem_ready,
    input  logic                 IR_LOAD,
    input  logic                 CCR_LOAD,
    input  logic                 MAR_LOAD,
    input  logic                 PC_LOAD,
    input  logic                 PC_INC,
    input  logic                 REG_LOAD,
    input  logic [REG_SEL_W-1:0] REG_WSEL,
    input  logic [REG_SEL_W-1:0] REG_ASEL,
    input  logic [REG_SEL_W-1:0] REG_BSEL,
    input  logic [2:0]           ALU_SEL,
    input  logic [1:0]           FROM_MEMORY_BUS_SEL,
    input  logic [1:0]           TO_MEMORY_BUS_SEL,
    output logic [WIDTH-1:0]     IR,
    output logic [3:0]           CCR,
    output logic [WIDTH-1:0]     address,
    output logic [WIDTH-1:0]     to_memory,
    output logic                 mem_req,
    output logic                 busy
);

    // ALU operation codes
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_INC  = 3'b101;
    localparam logic [2:0] OP_DEC  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // FROM bus sources
    localparam logic [1:0] FROM_ALU  = 2'b00;
    localparam logic [1:0] FROM_TO   = 2'b01;
    localparam logic [1:0] FROM_MEM  = 2'b10;
    localparam logic [1:0] FROM_ZERO = 2'b11;

    // TO bus sources
    localparam logic [1:0] TO_PC  = 2'b00;
    localparam logic [1:0] TO_RA  = 2'b01;
    localparam logic [1:0] TO_RB  = 2'b10;
    localparam logic [1:0] TO_MAR = 2'b11;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q;
    logic                 busy_q;
    logic                 mem_req_q;

    // Control captured when a memory load has to wait
    logic                 lat_ir_load_q;
    logic                 lat_ccr_load_q;
    logic                 lat_mar_load_q;
    logic                 lat_pc_load_q;
    logic                 lat_pc_inc_q;
    logic                 lat_reg_load_q;
    logic [REG_SEL_W-1:0] lat_wsel_q;
    logic [REG_SEL_W-1:0] lat_asel_q;
    logic [REG_SEL_W-1:0] lat_bsel_q;
    logic [2:0]           lat_alu_sel_q;
    logic [1:0]           lat_to_sel_q;

    logic [WIDTH-1:0]     rf_q [NREGS];
    logic [WIDTH-1:0]     pc_q,  pc_d;
    logic [WIDTH-1:0]     mar_q, mar_d;
    logic [WIDTH-1:0]     ir_q,  ir_d;
    logic [3:0]           ccr_q, ccr_d;

    // ------------------------------------------------------------------
    // Effective controls: live inputs in IDLE, captured copy in WAIT
    // ------------------------------------------------------------------
    logic                 eff_ir_load;
    logic                 eff_ccr_load;
    logic                 eff_mar_load;
    logic                 eff_pc_load;
    logic                 eff_pc_inc;
    logic                 eff_reg_load;
    logic [REG_SEL_W-1:0] eff_wsel;
    logic [REG_SEL_W-1:0] eff_asel;
    logic [REG_SEL_W-1:0] eff_bsel;
    logic [2:0]           eff_alu_sel;
    logic [1:0]           eff_to_sel;
    logic [1:0]           eff_from_sel;

    // Choose between live and captured control depending on FSM state
    always_comb begin
        if (state_q == ST_WAIT) begin
            eff_ir_load  = lat_ir_load_q;
            eff_ccr_load = lat_ccr_load_q;
            eff_mar_load = lat_mar_load_q;
            eff_pc_load  = lat_pc_load_q;
            eff_pc_inc   = lat_pc_inc_q;
            eff_reg_load = lat_reg_load_q;
            eff_wsel     = lat_wsel_q;
            eff_asel     = lat_asel_q;
            eff_bsel     = lat_bsel_q;
            eff_alu_sel  = lat_alu_sel_q;
            eff_to_sel   = lat_to_sel_q;
            eff_from_sel = FROM_MEM;       // only memory loads are ever deferred
        end else begin
            eff_ir_load  = IR_LOAD;
            eff_ccr_load = CCR_LOAD;
            eff_mar_load = MAR_LOAD;
            eff_pc_load  = PC_LOAD;
            eff_pc_inc   = PC_INC;
            eff_reg_load = REG_LOAD;
            eff_wsel     = REG_WSEL;
            eff_asel     = REG_ASEL;
            eff_bsel     = REG_BSEL;
            eff_alu_sel  = ALU_SEL;
            eff_to_sel   = TO_MEMORY_BUS_SEL;
            eff_from_sel = FROM_MEMORY_BUS_SEL;
        end
    end

    // A memory-sourced load with no valid data yet must be deferred
    logic mem_load_req;
    logic stall_enter;
    logic commit;

    assign mem_load_req = IR_LOAD | MAR_LOAD | PC_LOAD | REG_LOAD;
    assign stall_enter  = (state_q == ST_IDLE) && (FROM_MEMORY_BUS_SEL == FROM_MEM)
                          && mem_load_req && !mem_ready;
    // Strobes act in IDLE unless deferred, and in WAIT only once data arrives
    assign commit       = (state_q == ST_IDLE) ? !stall_enter : mem_ready;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] arith_b;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] alu_result;
    logic             flag_v;
    logic             flag_c;

    assign op_a = rf_q[eff_asel];
    assign op_b = rf_q[eff_bsel];

    // Compute result and V/C; inc/dec share the add/sub paths with B forced to 1
    always_comb begin
        arith_b = ((eff_alu_sel == OP_INC) || (eff_alu_sel == OP_DEC)) ? ONE : op_b;
        add_ext = {1'b0, op_a} + {1'b0, arith_b};
        sub_ext = {1'b0, op_a} - {1'b0, arith_b};   // top bit is the borrow
        alu_result = '0;
        flag_v     = 1'b0;
        flag_c     = 1'b0;
        case (eff_alu_sel)
            OP_ADD, OP_INC: begin
                alu_result = add_ext[WIDTH-1:0];
                flag_c     = add_ext[WIDTH];
                flag_v     = (op_a[WIDTH-1] == arith_b[WIDTH-1]) &&
                             (add_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB, OP_DEC: begin
                alu_result = sub_ext[WIDTH-1:0];
                flag_c     = sub_ext[WIDTH];
                flag_v     = (op_a[WIDTH-1] != arith_b[WIDTH-1]) &&
                             (sub_ext[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_PASS: alu_result = op_a;
            default: alu_result = '0;
        endcase
    end

    logic [3:0] alu_flags;
    assign alu_flags = {alu_result[WIDTH-1], (alu_result == '0), flag_v, flag_c};

    // ------------------------------------------------------------------
    // Buses
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] to_bus;
    logic [WIDTH-1:0] from_bus;

    // TO bus source select
    always_comb begin
        case (eff_to_sel)
            TO_PC:   to_bus = pc_q;
            TO_RA:   to_bus = op_a;
            TO_RB:   to_bus = op_b;
            TO_MAR:  to_bus = mar_q;
            default: to_bus = '0;
        endcase
    end

    // FROM bus source select; the zero source is an explicit constant
    always_comb begin
        case (eff_from_sel)
            FROM_ALU:  from_bus = alu_result;
            FROM_TO:   from_bus = to_bus;
            FROM_MEM:  from_bus = from_memory;
            FROM_ZERO: from_bus = '0;
            default:   from_bus = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Next-state for PC/MAR/IR/CCR; PC_LOAD wins over PC_INC
    always_comb begin
        pc_d  = pc_q;
        mar_d = mar_q;
        ir_d  = ir_q;
        ccr_d = ccr_q;
        if (commit) begin
            if (eff_pc_load) begin
                pc_d = from_bus;
            end else if (eff_pc_inc) begin
                pc_d = pc_q + ONE;
            end
            if (eff_mar_load) mar_d = from_bus;
            if (eff_ir_load)  ir_d  = from_bus;
            if (eff_ccr_load) ccr_d = alu_flags;
        end
    end

    // Register PC/MAR/IR/CCR
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= '0;
            mar_q <= '0;
            ir_q  <= '0;
            ccr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            ir_q  <= ir_d;
            ccr_q <= ccr_d;
        end
    end

    // One register-file entry per iteration, each with its own write decode
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
            logic [WIDTH-1:0] rf_d;
            assign rf_d = (commit && eff_reg_load && (eff_wsel == REG_SEL_W'(gi)))
                          ? from_bus : rf_q[gi];

            // Register-file entry storage
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rf_q[gi] <= '0;
                end else begin
                    rf_q[gi] <= rf_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake FSM with registered busy/mem_req and control capture
    // ------------------------------------------------------------------
    // IDLE <-> WAIT sequencing; on entry to WAIT, freeze the control word
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            busy_q         <= 1'b0;
            mem_req_q      <= 1'b0;
            lat_ir_load_q  <= 1'b0;
            lat_ccr_load_q <= 1'b0;
            lat_mar_load_q <= 1'b0;
            lat_pc_load_q  <= 1'b0;
            lat_pc_inc_q   <= 1'b0;
            lat_reg_load_q <= 1'b0;
            lat_wsel_q     <= '0;
            lat_asel_q     <= '0;
            lat_bsel_q     <= '0;
            lat_alu_sel_q  <= '0;
            lat_to_sel_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stall_enter) begin
                        state_q        <= ST_WAIT;
                        busy_q         <= 1'b1;
                        mem_req_q      <= 1'b1;
                        lat_ir_load_q  <= IR_LOAD;
                        lat_ccr_load_q <= CCR_LOAD;
                        lat_mar_load_q <= MAR_LOAD;
                        lat_pc_load_q  <= PC_LOAD;
                        lat_pc_inc_q   <= PC_INC;
                        lat_reg_load_q <= REG_LOAD;
                        lat_wsel_q     <= REG_WSEL;
                        lat_asel_q     <= REG_ASEL;
                        lat_bsel_q     <= REG_BSEL;
                        lat_alu_sel_q  <= ALU_SEL;
                        lat_to_sel_q   <= TO_MEMORY_BUS_SEL;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign IR        = ir_q;
    assign CCR       = ccr_q;
    assign address   = mar_q;
    assign to_memory = to_bus;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;

endmodule

// File: tb/tb_data_path_gen.sv
// Self-checking bench for data_path_gen: directed scenarios plus a randomized
// run, all compared against an arithmetic reference model of the datapath.
module tb_data_path_gen;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int SW = 2;

    logic          clk;
    logic          reset;
    logic [W-1:0]  from_memory;
    logic          mem_ready;
    logic          ir_load, ccr_load, mar_load, pc_load, pc_inc, reg_load;
    logic [SW-1:0] wsel, asel, bsel;
    logic [2:0]    alu_sel;
    logic [1:0]    from_sel, to_sel;
    logic [W-1:0]  ir_o;
    logic [3:0]    ccr_o;
    logic [W-1:0]  address_o;
    logic [W-1:0]  to_memory_o;
    logic          mem_req_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    data_path_gen #(.WIDTH(W), .NREGS(NR), .REG_SEL_W(SW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .from_memory         (from_memory),
        .mem_ready           (mem_ready),
        .IR_LOAD             (ir_load),
        .CCR_LOAD            (ccr_load),
        .MAR_LOAD            (mar_load),
        .PC_LOAD             (pc_load),
        .PC_INC              (pc_inc),
        .REG_LOAD            (reg_load),
        .REG_WSEL            (wsel),
        .REG_ASEL            (asel),
        .REG_BSEL            (bsel),
        .ALU_SEL             (alu_sel),
        .FROM_MEMORY_BUS_SEL (from_sel),
        .TO_MEMORY_BUS_SEL   (to_sel),
        .IR                  (ir_o),
        .CCR                 (ccr_o),
        .address             (address_o),
        .to_memory           (to_memory_o),
        .mem_req             (mem_req_o),
        .busy                (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [W-1:0]  m_r [NR];
    logic [W-1:0]  m_pc, m_mar, m_ir;
    logic [3:0]    m_ccr;
    bit            m_wait;
    // pending deferred load
    bit            p_ir, p_ccr, p_mar, p_pc, p_inc, p_reg;
    logic [SW-1:0] p_wsel, p_asel, p_bsel;
    logic [2:0]    p_alu;
    logic [1:0]    p_to;

    // Result and flags from plain integer arithmetic: {N,Z,V,C,result}
    function automatic logic [W+3:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int ua, ub, sa, sb, ures, sres;
        bit arith;
        logic [W-1:0] res;
        bit c, v;
        ua = int'(a);
        ub = int'(b);
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        arith = 1;
        sres = 0;
        case (op)
            3'd0: begin ures = ua + ub; sres = sa + sb; end
            3'd1: begin ures = ua - ub; sres = sa - sb; end
            3'd5: begin ures = ua + 1;  sres = sa + 1;  end
            3'd6: begin ures = ua - 1;  sres = sa - 1;  end
            3'd2: begin ures = int'(a & b); arith = 0; end
            3'd3: begin ures = int'(a | b); arith = 0; end
            3'd4: begin ures = int'(a ^ b); arith = 0; end
            default: begin ures = ua; arith = 0; end
        endcase
        res = ures[W-1:0];
        c = arith && (ures < 0 || ures > (1 << W) - 1);
        v = arith && (sres < -(1 << (W-1)) || sres > (1 << (W-1)) - 1);
        return {res[W-1], (res == 0), v, c, res};
    endfunction

    function automatic logic [W-1:0] model_to_bus();
        logic [1:0]    s;
        logic [SW-1:0] a, b;
        s = m_wait ? p_to : to_sel;
        a = m_wait ? p_asel : asel;
        b = m_wait ? p_bsel : bsel;
        case (s)
            2'd0: return m_pc;
            2'd1: return m_r[a];
            2'd2: return m_r[b];
            default: return m_mar;
        endcase
    endfunction

    task automatic model_apply(input bit l_ir, input bit l_ccr, input bit l_mar, input bit l_pc,
                               input bit l_inc, input bit l_reg, input logic [SW-1:0] ws,
                               input logic [SW-1:0] as, input logic [SW-1:0] bs,
                               input logic [2:0] op, input logic [1:0] ts,
                               input logic [1:0] fs, input logic [W-1:0] mem);
        logic [W+3:0] alu;
        logic [W-1:0] tov, bus;
        alu = alu_ref(op, m_r[as], m_r[bs]);
        case (ts)
            2'd0: tov = m_pc;
            2'd1: tov = m_r[as];
            2'd2: tov = m_r[bs];
            default: tov = m_mar;
        endcase
        case (fs)
            2'd0: bus = alu[W-1:0];
            2'd1: bus = tov;
            2'd2: bus = mem;
            default: bus = '0;
        endcase
        if (l_ir)  m_ir  = bus;
        if (l_ccr) m_ccr = alu[W+3:W];
        if (l_mar) m_mar = bus;
        if (l_pc)       m_pc = bus;
        else if (l_inc) m_pc = m_pc + 1'b1;
        if (l_reg) m_r[ws] = bus;
    endtask

    // Advance the model by one rising edge using the inputs currently driven
    task automatic model_step();
        if (!reset) begin
            for (int i = 0; i < NR; i++) m_r[i] = '0;
            m_pc = '0; m_mar = '0; m_ir = '0; m_ccr = '0; m_wait = 0;
        end else if (!m_wait) begin
            if (from_sel == 2'd2 && (ir_load | mar_load | pc_load | reg_load) && !mem_ready) begin
                m_wait = 1;
                p_ir = ir_load; p_ccr = ccr_load; p_mar = mar_load; p_pc = pc_load;
                p_inc = pc_inc; p_reg = reg_load; p_wsel = wsel; p_asel = asel;
                p_bsel = bsel; p_alu = alu_sel; p_to = to_sel;
            end else begin
                model_apply(ir_load, ccr_load, mar_load, pc_load, pc_inc, reg_load,
                            wsel, asel, bsel, alu_sel, to_sel, from_sel, from_memory);
            end
        end else if (mem_ready) begin
            model_apply(p_ir, p_ccr, p_mar, p_pc, p_inc, p_reg, p_wsel, p_asel, p_bsel,
                        p_alu, p_to, 2'd2, from_memory);
            m_wait = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        reset = 1'b1; from_memory = '0; mem_ready = 1'b0;
        ir_load = 0; ccr_load = 0; mar_load = 0; pc_load = 0; pc_inc = 0; reg_load = 0;
        wsel = '0; asel = '0; bsel = '0; alu_sel = '0; from_sel = '0; to_sel = '0;
    endtask

    task automatic load_reg(input logic [SW-1:0] idx, input logic [W-1:0] val);
        set_idle();
        from_sel = 2'd2; reg_load = 1; wsel = idx; mem_ready = 1; from_memory = val;
        tick();
        set_idle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        ir_load = 1; from_sel = 2'd3;
        tick();
        tick();
        set_idle();
        #1;
        checks++; if (ir_o !== '0) begin errors++; $display("FAIL reset_ir got %h want 00", ir_o); end
        checks++; if (ccr_o !== '0) begin errors++; $display("FAIL reset_ccr got %b want 0000", ccr_o); end
        checks++; if (address_o !== '0) begin errors++; $display("FAIL reset_address got %h want 00", address_o); end
        checks++; if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy got busy=%b mem_req=%b want 0 0", busy_o, mem_req_o);
        end
        checks++; if (to_memory_o !== '0) begin errors++; $display("FAIL reset_pc got %h want 00", to_memory_o); end
    endtask

    task automatic test_ir_ready();
        set_idle();
        from_sel = 2'd2; ir_load = 1; mem_ready = 1; from_memory = 8'h3C;
        tick();
        set_idle();
        checks++; if (ir_o !== 8'h3C) begin errors++; $display("FAIL ir_ready got %h want 3c", ir_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ir_ready_busy got %b want 0", busy_o); end
    endtask

    task automatic test_add_flags();
        load_reg(2'd0, 8'h7F);
        load_reg(2'd1, 8'h01);
        asel = 2'd0; bsel = 2'd1; alu_sel = 3'b000; from_sel = 2'd0;
        reg_load = 1; wsel = 2'd2; ccr_load = 1;
        tick();
        set_idle();
        to_sel = 2'd1; asel = 2'd2;
        #1;
        checks++; if (to_memory_o !== 8'h80) begin errors++; $display("FAIL add_result got %h want 80", to_memory_o); end
        checks++; if (ccr_o !== 4'b1010) begin errors++; $display("FAIL add_ccr got %b want 1010", ccr_o); end
    endtask

    task automatic test_sub_logic_flags();
        load_reg(2'd0, 8'h00);
        load_reg(2'd1, 8'h01);
        asel = 2'd0; bsel = 2'd1; alu_sel = 3'b001; ccr_load = 1;
        tick();
        set_idle();
        checks++; if (ccr_o !== 4'b1001) begin errors++; $display("FAIL sub_ccr got %b want 1001", ccr_o); end
        load_reg(2'd1, 8'h00);
        asel = 2'd0; bsel = 2'd1; alu_sel = 3'b010; ccr_load = 1;
        tick();
        set_idle();
        checks++; if (ccr_o !== 4'b0100) begin errors++; $display("FAIL and_ccr got %b want 0100", ccr_o); end
    endtask

    task automatic test_stall();
        logic [W-1:0] ir_before;
        logic [3:0]   ccr_before;
        int busy_cycles;
        set_idle();
        ir_before = m_ir;
        ccr_before = m_ccr;
        from_sel = 2'd2; mar_load = 1; to_sel = 2'd3; mem_ready = 0; from_memory = 8'h11;
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_ready = 1; from_memory = 8'hA5; end
            tick();
            if (busy_o === 1'b1) busy_cycles++;
            // toggle external controls; all should be ignored while stalled
            ir_load = 1; pc_load = 1; pc_inc = 1; reg_load = 1; ccr_load = 1; mar_load = 0;
            from_sel = 2'($urandom_range(0, 3)); to_sel = 2'($urandom_range(0, 2));
            alu_sel = 3'($urandom_range(0, 7)); wsel = 2'($urandom_range(0, 3));
            asel = 2'($urandom_range(0, 3)); bsel = 2'($urandom_range(0, 3));
            #1;
            if (i < 3) begin
                checks++; if (to_memory_o !== model_to_bus()) begin
                    errors++; $display("FAIL stall_to_bus got %h want %h", to_memory_o, model_to_bus());
                end
            end
        end
        set_idle();
        checks++; if (busy_cycles !== 3) begin errors++; $display("FAIL stall_busy_cycles got %0d want 3", busy_cycles); end
        checks++; if (address_o !== 8'hA5) begin errors++; $display("FAIL stall_address got %h want a5", address_o); end
        checks++; if (ir_o !== ir_before) begin errors++; $display("FAIL stall_ir got %h want %h", ir_o, ir_before); end
        checks++; if (ccr_o !== ccr_before) begin errors++; $display("FAIL stall_ccr got %b want %b", ccr_o, ccr_before); end
        checks++; if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL stall_release got busy=%b mem_req=%b want 0 0", busy_o, mem_req_o);
        end
        for (int r = 0; r < NR; r++) begin
            to_sel = 2'd1; asel = 2'(r);
            #1;
            checks++; if (to_memory_o !== m_r[r]) begin
                errors++; $display("FAIL stall_reg%0d got %h want %h", r, to_memory_o, m_r[r]);
            end
        end
        to_sel = 2'd0;
        #1;
        checks++; if (to_memory_o !== m_pc) begin errors++; $display("FAIL stall_pc got %h want %h", to_memory_o, m_pc); end
        set_idle();
    endtask

    task automatic test_pc_wrap();
        set_idle();
        from_sel = 2'd2; pc_load = 1; mem_ready = 1; from_memory = 8'hFF;
        tick();
        set_idle();
        pc_inc = 1;
        tick();
        set_idle();
        #1;
        checks++; if (to_memory_o !== 8'h00) begin errors++; $display("FAIL pc_wrap got %h want 00", to_memory_o); end
        from_sel = 2'd2; mar_load = 1; mem_ready = 1; from_memory = 8'h40;
        tick();
        set_idle();
        from_sel = 2'd1; to_sel = 2'd3; pc_load = 1; pc_inc = 1;
        tick();
        set_idle();
        #1;
        checks++; if (to_memory_o !== 8'h40) begin errors++; $display("FAIL pc_load_prio got %h want 40", to_memory_o); end
    endtask

    task automatic test_reset_mid_wait();
        load_reg(2'd3, 8'h5A);
        from_sel = 2'd2; ir_load = 1; reg_load = 1; wsel = 2'd3; mem_ready = 0; from_memory = 8'h99;
        tick();
        checks++; if (busy_o !== 1'b1 || mem_req_o !== 1'b1) begin
            errors++; $display("FAIL wait_entry got busy=%b mem_req=%b want 1 1", busy_o, mem_req_o);
        end
        reset = 1'b0; mem_ready = 1;
        tick();
        set_idle();
        mem_ready = 1; from_memory = 8'h99;
        tick();
        set_idle();
        to_sel = 2'd1; asel = 2'd3;
        #1;
        checks++; if (ir_o !== 8'h00) begin errors++; $display("FAIL rst_wait_ir got %h want 00", ir_o); end
        checks++; if (to_memory_o !== 8'h00) begin errors++; $display("FAIL rst_wait_r3 got %h want 00", to_memory_o); end
        checks++; if (busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++; $display("FAIL rst_wait_busy got busy=%b mem_req=%b want 0 0", busy_o, mem_req_o);
        end
        checks++; if (address_o !== 8'h00) begin errors++; $display("FAIL rst_wait_address got %h want 00", address_o); end
        set_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) != 0);
            mem_ready = ($urandom_range(0, 9) < 6);
            from_memory = W'($urandom);
            ir_load = ($urandom_range(0, 3) == 0); ccr_load = ($urandom_range(0, 2) == 0);
            mar_load = ($urandom_range(0, 3) == 0); pc_load = ($urandom_range(0, 4) == 0);
            pc_inc = ($urandom_range(0, 2) == 0); reg_load = ($urandom_range(0, 1) == 0);
            wsel = SW'($urandom); asel = SW'($urandom); bsel = SW'($urandom);
            alu_sel = 3'($urandom); from_sel = 2'($urandom); to_sel = 2'($urandom);
            #1;
            checks++; if (to_memory_o !== model_to_bus()) begin
                errors++; $display("FAIL rnd_to_bus n=%0d got %h want %h", n, to_memory_o, model_to_bus());
            end
            tick();
            checks++; if (ir_o !== m_ir) begin errors++; $display("FAIL rnd_ir n=%0d got %h want %h", n, ir_o, m_ir); end
            checks++; if (ccr_o !== m_ccr) begin errors++; $display("FAIL rnd_ccr n=%0d got %b want %b", n, ccr_o, m_ccr); end
            checks++; if (address_o !== m_mar) begin errors++; $display("FAIL rnd_address n=%0d got %h want %h", n, address_o, m_mar); end
            checks++; if (busy_o !== m_wait || mem_req_o !== m_wait) begin
                errors++; $display("FAIL rnd_busy n=%0d got busy=%b mem_req=%b want %b", n, busy_o, mem_req_o, m_wait);
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_ir_ready();
        test_add_flags();
        test_sub_logic_flags();
        test_stall();
        test_pc_wrap();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
